// File: rtl/sim_pkg.sv
// Shared definitions for the simulation run controller: FSM state encoding and
// default parameter values.
package sim_pkg;

    // One-hot encoding; any illegal pattern is steered back to IDLE by the FSM.
    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_RST     = 5'b00010,
        S_RUN     = 5'b00100,
        S_HALTED  = 5'b01000,
        S_TIMEOUT = 5'b10000
    } run_state_e;

    localparam int unsigned DEF_RST_CYCLES  = 4;
    localparam logic [31:0] DEF_MAX_CYCLES  = 32'd100000;
    localparam int unsigned DEF_HALT_REPEAT = 3;
    localparam int unsigned DEF_PC_W        = 32;
    localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/selfloop_det.sv
// Self-loop detector: flags the retirement that makes the same PC retire
// HALT_REPEAT times in a row.
module selfloop_det
    import sim_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            retire_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            hit_o
);

    localparam int unsigned      REP_W   = $clog2(HALT_REPEAT + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(HALT_REPEAT);
    localparam logic [REP_W-1:0] REP_HIT = REP_W'(HALT_REPEAT - 1);

    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic             last_vld_q, last_vld_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             same_pc;

    // The valid flag keeps a first retire at PC 0 from matching the cleared register.
    always_comb begin
        same_pc    = last_vld_q && (pc_i == last_pc_q);
        hit_o      = retire_i && same_pc && (rep_q >= REP_HIT);
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        rep_d      = rep_q;
        if (clear_i) begin
            last_pc_d  = '0;
            last_vld_d = 1'b0;
            rep_d      = '0;
        end else if (retire_i) begin
            last_pc_d  = pc_i;
            last_vld_d = 1'b1;
            if (!same_pc)
                rep_d = REP_W'(1);
            else if (rep_q != REP_MAX)
                rep_d = rep_q + REP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            rep_q      <= '0;
        end else begin
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            rep_q      <= rep_d;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for a CPU under simulation: holds the CPU in reset, runs it,
// and ends the run on a detected self-loop halt or a cycle-budget timeout.
module sim_run_ctrl
    import sim_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
    parameter logic [31:0] MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             retire,
    input  logic [PC_W-1:0]  retire_pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [PC_W-1:0]  halt_pc
);

    localparam int unsigned      RC_W     = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 32'd1);

    run_state_e       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic             cpu_reset_q;
    logic             enter_rst;
    logic             run_retire;
    logic             halt_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Derived from state_q only, so it cannot loop back through the detector.
    assign enter_rst  = start && ((state_q == S_IDLE) || (state_q == S_HALTED) ||
                                  (state_q == S_TIMEOUT));
    assign run_retire = retire && (state_q == S_RUN);

    selfloop_det #(
        .PC_W        (PC_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_det (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (enter_rst),
        .retire_i (run_retire),
        .pc_i     (retire_pc),
        .hit_o    (halt_hit)
    );

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        halt_pc_d    = halt_pc_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RST;
            S_RST: begin
                if (rst_cnt_q == '0) state_d = S_RUN;
                else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
            end
            S_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (retire) retire_cnt_d = sat_inc(retire_cnt_q);
                // Halt takes priority over a timeout landing on the same cycle.
                if (halt_hit) begin
                    state_d   = S_HALTED;
                    halt_pc_d = retire_pc;
                end else if (cycle_cnt_q == CYC_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_HALTED, S_TIMEOUT: if (start) state_d = S_RST;
            default: state_d = S_IDLE;
        endcase
        if (enter_rst) begin
            rst_cnt_d    = RC_LOAD;
            cycle_cnt_d  = '0;
            retire_cnt_d = '0;
            halt_pc_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            halt_pc_q    <= '0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            halt_pc_q    <= halt_pc_d;
            cpu_reset_q  <= (state_d == S_IDLE) || (state_d == S_RST);
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_HALTED);
    assign timeout    = (state_q == S_TIMEOUT);
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign halt_pc    = halt_pc_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: stimulus queues expected run-start and
// run-end events, a monitor compares them when the DUT signals each event.
module tb_sim_run_ctrl;

    logic        clk, reset, start, retire;
    logic [31:0] retire_pc;
    logic        cpu_reset, running, done, timeout;
    logic [31:0] cycle_cnt, retire_cnt, halt_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] kind;
        logic [31:0] rst_len;
        logic [31:0] dn;
        logic [31:0] tmo;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] hpc;
        logic [31:0] run_len;
        bit          use_lag;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    sim_run_ctrl #(
        .RST_CYCLES  (4),
        .MAX_CYCLES  (32'd20),
        .HALT_REPEAT (3),
        .PC_W        (32),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .retire     (retire),
        .retire_pc  (retire_pc),
        .cpu_reset  (cpu_reset),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt),
        .halt_pc    (halt_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_run(input string tag);
        exp_t e;
        e.kind = 32'd0; e.rst_len = 32'd4; e.dn = 32'd0; e.tmo = 32'd0;
        e.cyc = 32'd0; e.ret = 32'd0; e.hpc = 32'd0; e.run_len = 32'd0; e.use_lag = 1'b0;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_end(input string tag, input logic [31:0] dn, input logic [31:0] tmo,
                            input logic [31:0] cyc, input logic [31:0] ret,
                            input logic [31:0] hpc, input logic [31:0] run_len, input bit lag);
        exp_t e;
        e.kind = 32'd1; e.rst_len = 32'd0; e.dn = dn; e.tmo = tmo;
        e.cyc = cyc; e.ret = ret; e.hpc = hpc; e.run_len = run_len; e.use_lag = lag;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: one process handles both edges so its bookkeeping has a single writer.
    initial begin : monitor
        logic [31:0] cyc, last_ret, rst_len, run_len;
        bit          armed;
        logic        p_run, p_done, p_tmo;
        exp_t        e;
        string       t;
        cyc = 0; last_ret = 0; rst_len = 0; run_len = 0;
        armed = 1'b0; p_run = 1'b0; p_done = 1'b0; p_tmo = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (retire) last_ret = cyc;
            if (reset && start && !p_run && !armed) begin
                armed   = 1'b1;
                rst_len = 0;
            end
            @(negedge clk);
            if (!reset) begin
                armed   = 1'b0;
                rst_len = 0;
                run_len = 0;
            end else begin
                if (armed && cpu_reset) rst_len++;
                if (running && !p_run) begin
                    run_len = 1;
                    armed   = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow_run", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        t = tag_q.pop_front();
                        chk({t, "_kind"},       32'd0,       e.kind);
                        chk({t, "_rst_len"},    rst_len,     e.rst_len);
                        chk({t, "_cyc0"},       cycle_cnt,   e.cyc);
                        chk({t, "_ret0"},       retire_cnt,  e.ret);
                        chk({t, "_hpc0"},       halt_pc,     e.hpc);
                        chk({t, "_cpu_rst_lo"}, {31'b0, cpu_reset}, 32'd0);
                    end
                end else if (running) begin
                    run_len++;
                end
                if ((done && !p_done) || (timeout && !p_tmo)) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow_end", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        t = tag_q.pop_front();
                        chk({t, "_kind"},    32'd1,            e.kind);
                        chk({t, "_done"},    {31'b0, done},    e.dn);
                        chk({t, "_timeout"}, {31'b0, timeout}, e.tmo);
                        chk({t, "_cyc"},     cycle_cnt,        e.cyc);
                        chk({t, "_ret"},     retire_cnt,       e.ret);
                        chk({t, "_hpc"},     halt_pc,          e.hpc);
                        chk({t, "_run_len"}, run_len,          e.run_len);
                        if (e.use_lag) chk({t, "_lag"}, cyc - last_ret, 32'd0);
                    end
                end
            end
            p_run  = running;
            p_done = done;
            p_tmo  = timeout;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic s);
        retire    = r;
        retire_pc = pc;
        start     = s;
    endtask

    task automatic feed(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0);
        step();
    endtask

    task automatic pulse_start();
        drive(1'b0, 32'd0, 1'b1);
        step();
        drive(1'b0, 32'd0, 1'b0);
    endtask

    // which: 0 running, 1 done, 2 timeout. Returns at the negedge where it is seen.
    task automatic wait_out(input int which, input int budget, input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            seen = (which == 0) ? running : (which == 1) ? done : timeout;
            if (seen) break;
        end
        if (!seen) chk({nm, "_wait_expired"}, 32'd0, 32'd1);
    endtask

    initial begin : stim
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        repeat (3) step();
        chk("rst_cpu_reset",  {31'b0, cpu_reset}, 32'd1);
        chk("rst_running",    {31'b0, running},   32'd0);
        chk("rst_done",       {31'b0, done},      32'd0);
        chk("rst_timeout",    {31'b0, timeout},   32'd0);
        chk("rst_cycle_cnt",  cycle_cnt,          32'd0);
        chk("rst_retire_cnt", retire_cnt,         32'd0);
        chk("rst_halt_pc",    halt_pc,            32'd0);
        reset = 1'b1;
        repeat (2) step();
        chk("idle_running",   {31'b0, running},   32'd0);
        chk("idle_cpu_reset", {31'b0, cpu_reset}, 32'd1);

        // A: 0x3000,0x3004,(bubble),0x3008 x3 -> halt at 0x3008
        push_run("A_run");
        push_end("A_end", 32'd1, 32'd0, 32'd6, 32'd5, 32'h3008, 32'd6, 1'b1);
        pulse_start();
        wait_out(0, 20, "A_run");
        feed(32'h3000);
        feed(32'h3004);
        drive(1'b0, 32'd0, 1'b0); step();
        feed(32'h3008);
        feed(32'h3008);
        feed(32'h3008);
        chk("A_done_next", {31'b0, done}, 32'd1);
        drive(1'b1, 32'h3008, 1'b0);
        repeat (3) step();
        drive(1'b0, 32'd0, 1'b0);
        chk("A_frz_cyc", cycle_cnt,  32'd6);
        chk("A_frz_ret", retire_cnt, 32'd5);
        chk("A_frz_hpc", halt_pc,    32'h3008);

        // B: rerun from HALTED; starts in RST and RUN are ignored
        push_run("B_run");
        push_end("B_end", 32'd1, 32'd0, 32'd5, 32'd5, 32'h14, 32'd5, 1'b1);
        pulse_start();
        step();
        pulse_start();
        wait_out(0, 20, "B_run");
        drive(1'b1, 32'h10, 1'b1); step();
        feed(32'h10);
        feed(32'h14);
        feed(32'h14);
        feed(32'h14);
        drive(1'b0, 32'd0, 1'b0);
        wait_out(1, 5, "B_done");

        // C: distinct PCs every cycle -> timeout after 20 RUN cycles
        push_run("C_run");
        push_end("C_end", 32'd0, 32'd1, 32'd20, 32'd20, 32'd0, 32'd20, 1'b0);
        pulse_start();
        wait_out(0, 20, "C_run");
        for (int k = 0; k < 40; k++) begin
            if (timeout || done) break;
            feed(32'h100 + 32'(4 * k));
        end
        drive(1'b0, 32'd0, 1'b0);
        repeat (3) step();
        chk("C_frz_cyc", cycle_cnt,          32'd20);
        chk("C_frz_ret", retire_cnt,         32'd20);
        chk("C_tmo",     {31'b0, timeout},   32'd1);
        chk("C_done",    {31'b0, done},      32'd0);

        // D: halt lands on the last budget cycle -> halt wins
        push_run("D_run");
        push_end("D_end", 32'd1, 32'd0, 32'd20, 32'd20, 32'h500, 32'd20, 1'b1);
        pulse_start();
        wait_out(0, 20, "D_run");
        for (int k = 0; k < 20; k++)
            feed((k >= 17) ? 32'h500 : 32'h200 + 32'(4 * k));
        drive(1'b0, 32'd0, 1'b0);
        repeat (2) step();
        chk("D_tmo",  {31'b0, timeout}, 32'd0);
        chk("D_done", {31'b0, done},    32'd1);

        // E: async reset at RUN cycle 7, then a fresh run
        push_run("E1_run");
        pulse_start();
        wait_out(0, 20, "E1_run");
        feed(32'h40);
        feed(32'h40);
        drive(1'b0, 32'd0, 1'b0);
        repeat (5) step();
        chk("E_pre_cyc", cycle_cnt,  32'd7);
        chk("E_pre_ret", retire_cnt, 32'd2);
        reset = 1'b0;
        #1;
        chk("E_rst_cpu_reset",  {31'b0, cpu_reset}, 32'd1);
        chk("E_rst_running",    {31'b0, running},   32'd0);
        chk("E_rst_done",       {31'b0, done},      32'd0);
        chk("E_rst_timeout",    {31'b0, timeout},   32'd0);
        chk("E_rst_cycle_cnt",  cycle_cnt,          32'd0);
        chk("E_rst_retire_cnt", retire_cnt,         32'd0);
        chk("E_rst_halt_pc",    halt_pc,            32'd0);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        chk("E_idle_running",   {31'b0, running},   32'd0);
        chk("E_idle_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        push_run("E2_run");
        push_end("E2_end", 32'd1, 32'd0, 32'd3, 32'd3, 32'h40, 32'd3, 1'b1);
        pulse_start();
        wait_out(0, 20, "E2_run");
        feed(32'h40);
        feed(32'h40);
        feed(32'h40);
        drive(1'b0, 32'd0, 1'b0);
        wait_out(1, 5, "E2_done");

        repeat (3) step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameters SHALL be: RST_CYCLES, 4, cycles cpu_reset is held high per run (>=1).
REQ-002 MAX_CYCLES, 32'd100000, run-cycle budget before timeout (>=1).
REQ-003 HALT_REPEAT, 3, consecutive same-PC retirements that declare halt (>=2).
REQ-004 PC_W, 32, program-counter width; CNT_W, 32, counter width.
REQ-005 Ports SHALL be: clk  in  1  single clock, all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-low block reset.
REQ-007 start  in  1  one-cycle pulse requesting a new run.
REQ-008 retire  in  1  CPU retired one instruction this cycle.
REQ-009 retire_pc  in  PC_W  PC of the retired instruction, valid when retire=1.
REQ-010 cpu_reset  out  1  synchronous active-high reset to the CPU under test.
REQ-011 running  out  1  high while in RUN.
REQ-012 done  out  1  high in HALTED; timeout  out  1  high in TIMEOUT.
REQ-013 cycle_cnt  out  CNT_W  RUN cycles elapsed; retire_cnt  out  CNT_W  retirements counted.
REQ-014 halt_pc  out  PC_W  PC of the self-loop that caused halt.

Function
REQ-015 FSM states SHALL be IDLE, RST, RUN, HALTED, TIMEOUT; encoding one-hot-safe, default arm to IDLE.
REQ-016 IDLE: start=1 -> RST next cycle; otherwise stay.
REQ-017 RST: cpu_reset=1; down-counter loaded with RST_CYCLES-1 on entry; at zero -> RUN; cpu_reset high exactly RST_CYCLES cycles.
REQ-018 Entry to RST SHALL clear cycle_cnt, retire_cnt, halt_pc, repeat counter and last-PC register.
REQ-019 RUN: cycle_cnt increments every cycle; retire_cnt increments on each retire; retire ignored outside RUN.
REQ-020 Halt detect: on retire, if retire_pc equals last retired PC, repeat count +1, else repeat count resets to 1; last PC updated on every retire; first retire after RST counts as 1.
REQ-021 Repeat count reaching HALT_REPEAT SHALL move RUN -> HALTED next cycle and latch halt_pc=retire_pc.
REQ-022 cycle_cnt reaching MAX_CYCLES-1 in RUN SHALL move RUN -> TIMEOUT next cycle.
REQ-023 Halt and timeout in the same cycle: HALTED wins; timeout stays 0.
REQ-024 HALTED/TIMEOUT: counters frozen, outputs held; start=1 -> RST (rerun); start ignored in RST and RUN.
REQ-025 Counters SHALL saturate at all-ones, never wrap.
REQ-026 Outputs SHALL be registered; running/done/timeout decode the state register only.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, cpu_reset=1, running=0, done=0, timeout=0, cycle_cnt=0, retire_cnt=0, halt_pc=0, internal counters 0.
REQ-028 In IDLE cpu_reset SHALL stay 1 so the CPU is held until a run starts.
REQ-029 reset asserted mid-run SHALL abort immediately; deassertion resumes in IDLE, no run restarts without start.

Structure
REQ-030 State enum and default parameter constants SHALL live in shared package sim_pkg.
REQ-031 Halt detector (last PC, repeat counter, compare) SHALL be sub-module selfloop_det; FSM and counters stay in sim_run_ctrl.

Verification
REQ-032 reset low 3 cycles, release, start pulse, RST_CYCLES=4 -> cpu_reset high exactly 4 cycles after start, then running=1.
REQ-033 retire PCs 0x3000,0x3004,0x3008,0x3008,0x3008 -> done=1 one cycle after third 0x3008, halt_pc=0x3008, retire_cnt=5.
REQ-034 MAX_CYCLES=20, no repeated PC -> timeout=1 after 20 RUN cycles, cycle_cnt=20 frozen.
REQ-035 Halt condition on RUN cycle MAX_CYCLES-1 -> done=1, timeout=0.
REQ-036 reset low mid-RUN at cycle 7 -> all outputs at reset values same cycle; start after release -> fresh run, counters from 0.
REQ-037 start in HALTED -> RST, counters cleared, second program halts with new halt_pc.
